spectrum_fetch_buffer: RTL and testbench

Downstream consumer of the AXI reader unit: requests spectrum bins one byte at a time over the reader's `read_signal`/`read_valid` handshake, stores `NUM_BINS` bytes in a local buffer, then holds the complete frame for the bin-ratio SNN ensemble. The ensemble reads the frame through two independent read ports, one per ratio operand, and releases it when inference finishes. The block decouples AXI-lite fetch latency from the SNN's random-access bin reads.

---
 rtl/snn_input_pkg.sv | 19 +
 rtl/spectrum_bin_ram.sv | 40 ++++
 rtl/spectrum_fetch_buffer.sv | 121 ++++++++++++
 tb/tb_spectrum_fetch_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_input_pkg.sv
// Shared definitions for the spectrum fetch path feeding the bin-ratio SNN:
// the default frame size, the bin address width and the fetch FSM states.
package snn_input_pkg;

  localparam int NUM_BINS_DEFAULT = 1024;

  // Bin address width for a frame of n bins.
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/spectrum_bin_ram.sv
// Frame store: one write port and two independent registered read ports.
// Contents are cleared by reset, so a never-written frame reads as zeros.
// A read and a write to the same address in one cycle return the old byte.
module spectrum_bin_ram
  import snn_input_pkg::*;
#(
  parameter int DEPTH = NUM_BINS_DEFAULT,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [7:0]    rd_data_a,
  output logic [7:0]    rd_data_b
);

  logic [7:0] mem [DEPTH];

  // Storage write plus registered reads; reads sample the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
  end

endmodule

// File: rtl/spectrum_fetch_buffer.sv
// Fetches one spectrum frame a byte at a time from the AXI reader and holds
// it for the SNN ensemble until released. Optional frame byte total is
// built when SPECTRUM_SUM_EN is defined.
//
// state | meaning
// IDLE  | no fetch in progress; waiting for start
// REQ   | read_signal pulsed for the byte at wr_ptr
// WAIT  | waiting for read_valid with that byte
// FULL  | complete frame held; waiting for frame_release
module spectrum_fetch_buffer
  import snn_input_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEFAULT,
  parameter int AW       = addr_width(NUM_BINS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          read_signal,
  input  logic          read_valid,
  input  logic [7:0]    in_data,
  output logic          busy,
  output logic          frame_valid,
  input  logic          frame_release,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [7:0]    rd_data_a,
  output logic [7:0]    rd_data_b
`ifdef SPECTRUM_SUM_EN
  ,
  output logic [AW+7:0] bin_sum
`endif
);

  localparam logic [AW-1:0] LAST_BIN = AW'(NUM_BINS - 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [AW-1:0] wr_ptr;
  logic          wr_en;
  logic          capture;
  logic          last_byte;

  assign capture   = (state == IDLE) && start;
  assign wr_en     = (state == WAIT) && read_valid;
  assign last_byte = (wr_ptr == LAST_BIN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; release wins over start in FULL since start is only seen in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)         state_next = REQ;
      REQ:                     state_next = WAIT;
      WAIT: if (read_valid)    state_next = last_byte ? FULL : REQ;
      FULL: if (frame_release) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    read_signal = 1'b0;
    busy        = 1'b0;
    frame_valid = 1'b0;
    case (state)
      REQ:  begin read_signal = 1'b1; busy = 1'b1; end
      WAIT: busy        = 1'b1;
      FULL: frame_valid = 1'b1;
      default: ;
    endcase
  end

  // Write pointer: cleared on start, advanced after every byte except the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (capture) begin
      wr_ptr <= '0;
    end else if (wr_en && !last_byte) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

`ifdef SPECTRUM_SUM_EN
  // Frame byte total; AW+8 bits cannot overflow for NUM_BINS bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sum <= '0;
    end else if (capture) begin
      bin_sum <= '0;
    end else if (wr_en) begin
      bin_sum <= bin_sum + (AW + 8)'(in_data);
    end
  end
`endif

  spectrum_bin_ram #(
    .DEPTH (NUM_BINS),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_ptr),
    .wr_data   (in_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

endmodule

// File: tb/tb_spectrum_fetch_buffer.sv
// Directed bench for spectrum_fetch_buffer with a 4-bin frame.
module tb_spectrum_fetch_buffer;
  localparam int NB = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          read_signal;
  logic          read_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          busy;
  logic          frame_valid;
  logic          frame_release = 1'b0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [7:0]    rd_data_a;
  logic [7:0]    rd_data_b;
`ifdef SPECTRUM_SUM_EN
  logic [AW+7:0] bin_sum;
`endif

  int vectors = 0;
  int miscompares = 0;
  int rs_count = 0;

  spectrum_fetch_buffer #(.NUM_BINS(NB), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .read_signal   (read_signal),
    .read_valid    (read_valid),
    .in_data       (in_data),
    .busy          (busy),
    .frame_valid   (frame_valid),
    .frame_release (frame_release),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b)
`ifdef SPECTRUM_SUM_EN
    ,
    .bin_sum       (bin_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (read_signal === 1'b1) rs_count <= rs_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rs();
    int n = 0;
    while (read_signal !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("read_signal_seen", 32'(read_signal), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [7:0] d);
    repeat (dly) tick();
    read_valid = 1'b1;
    in_data    = d;
    tick();
    read_valid = 1'b0;
    in_data    = '0;
  endtask

  task automatic fetch_byte(input logic [7:0] d);
    wait_rs();
    respond(3, d);
  endtask

  logic [7:0] frame1 [NB];
  logic [7:0] frame2 [NB];

  initial begin
    frame1[0] = 8'h11; frame1[1] = 8'h22; frame1[2] = 8'h33; frame1[3] = 8'h44;
    frame2[0] = 8'h01; frame2[1] = 8'h02; frame2[2] = 8'h03; frame2[3] = 8'h04;

    // Reset state
    repeat (2) tick();
    check("rst_read_signal", 32'(read_signal), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_rd_data_a",   32'(rd_data_a),   32'd0);
    check("rst_rd_data_b",   32'(rd_data_b),   32'd0);
    rst = 1'b0;
    tick();

    // Basic fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_rs_next_cycle", 32'(read_signal), 32'd1);
    check("start_busy",          32'(busy),        32'd1);
    for (int i = 0; i < NB; i++) fetch_byte(frame1[i]);
    check("f1_frame_valid", 32'(frame_valid), 32'd1);
    check("f1_busy_low",    32'(busy),        32'd0);
    check("f1_rs_low",      32'(read_signal), 32'd0);
    check("f1_rs_count",    32'(rs_count),    32'd4);
    for (int i = 0; i < NB; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NB - 1 - i);
      tick();
      check("f1_rd_a", 32'(rd_data_a), 32'(frame1[i]));
      check("f1_rd_b", 32'(rd_data_b), 32'(frame1[NB - 1 - i]));
    end
`ifdef SPECTRUM_SUM_EN
    check("f1_bin_sum", 32'(bin_sum), 32'h0AA);
`endif

    // Release, then spurious read_valid in IDLE
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check("rel_frame_valid", 32'(frame_valid), 32'd0);
    check("rel_busy",        32'(busy),        32'd0);
    read_valid = 1'b1; in_data = 8'hFF;
    tick();
    read_valid = 1'b0; in_data = '0;
    check("spur_idle_busy", 32'(busy),        32'd0);
    check("spur_idle_rs",   32'(read_signal), 32'd0);
    rd_addr_a = 2'd0;
    tick();
    check("spur_idle_buf0", 32'(rd_data_a), 32'h11);
    check("spur_idle_rs_count", 32'(rs_count), 32'd4);

    // Second frame with spurious read_valid in REQ and a same-cycle collision on bin 2
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f2_rs_high", 32'(read_signal), 32'd1);
    read_valid = 1'b1; in_data = 8'hFF;
    tick();
    read_valid = 1'b0; in_data = '0;
    check("spur_req_rs_low", 32'(read_signal), 32'd0);
    check("spur_req_busy",   32'(busy),        32'd1);
    respond(2, frame2[0]);
    fetch_byte(frame2[1]);
    wait_rs();
    rd_addr_a = 2'd2;
    respond(3, frame2[2]);
    check("collide_old", 32'(rd_data_a), 32'h33);
    fetch_byte(frame2[3]);
    check("collide_new", 32'(rd_data_a), 32'h03);
    check("f2_frame_valid", 32'(frame_valid), 32'd1);
    check("f2_rs_count",    32'(rs_count),    32'd8);
`ifdef SPECTRUM_SUM_EN
    check("f2_bin_sum", 32'(bin_sum), 32'h00A);
`endif
    for (int i = 0; i < NB; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(i);
      tick();
      check("f2_rd_a", 32'(rd_data_a), 32'(frame2[i]));
      check("f2_rd_b", 32'(rd_data_b), 32'(frame2[i]));
    end

    // start and frame_release together in FULL
    start = 1'b1; frame_release = 1'b1;
    tick();
    start = 1'b0; frame_release = 1'b0;
    check("coll_frame_valid", 32'(frame_valid), 32'd0);
    check("coll_busy",        32'(busy),        32'd0);
    check("coll_rs",          32'(read_signal), 32'd0);
    repeat (2) tick();
    check("coll_rs_count", 32'(rs_count), 32'd8);
    check("coll_idle",     32'(busy),     32'd0);

    // Reset mid-fetch with a late read_valid
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_byte(8'h66);
    fetch_byte(8'h77);
    tick();
    check("mid_busy_wait", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy),        32'd0);
    check("mid_rst_rs",    32'(read_signal), 32'd0);
    check("mid_rst_fv",    32'(frame_valid), 32'd0);
    check("mid_rst_rd_a",  32'(rd_data_a),   32'd0);
    check("mid_rst_rd_b",  32'(rd_data_b),   32'd0);
    tick();
    rst = 1'b0;
    tick();
    read_valid = 1'b1; in_data = 8'h55;
    tick();
    read_valid = 1'b0; in_data = '0;
    check("late_busy", 32'(busy),        32'd0);
    check("late_rs",   32'(read_signal), 32'd0);
`ifdef SPECTRUM_SUM_EN
    check("late_bin_sum", 32'(bin_sum), 32'd0);
`endif
    for (int i = 0; i < NB; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NB - 1 - i);
      tick();
      check("cleared_rd_a", 32'(rd_data_a), 32'd0);
      check("cleared_rd_b", 32'(rd_data_b), 32'd0);
    end
    check("final_rs_count", 32'(rs_count), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
